// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the FP32 operand alignment front end.
//   - Field widths of the IEEE-754 single format and of the internal
//     {hidden, frac, G, R, S} significand.
//   - Canonical quiet NaN and +Inf encodings used for bypass results.
//   - Alignment FSM state type.
//   - Unpacked operand record and the helper that builds it.
// ---------------------------------------------------------------------------
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = 27;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        ALIGN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } operand_t;

    // Denormals (and zero) take an effective exponent of 1 and a cleared
    // hidden bit so that they line up with the smallest normal binade.
    function automatic operand_t unpack_op(input logic [31:0] x, input logic flip);
        operand_t op;
        op.sign = x[31] ^ flip;
        op.exp  = (x[30:23] == '0) ? EXP_W'(1) : x[30:23];
        op.sig  = {(x[30:23] != '0), x[22:0], 3'b000};
        return op;
    endfunction

endpackage

// File: rtl/fp32_sticky_shifter.sv
// ---------------------------------------------------------------------------
// fp32_sticky_shifter
// Combinational right shift of a 27-bit significand by 0..8 positions.
// Every bit pushed off the bottom, including the incoming bit 0, is ORed into
// the new bit 0, so a sticky bit once set is never lost.
//   sig_in   [26:0]  significand before this step
//   amount   [3:0]   shift distance, 0..8
//   sig_out  [26:0]  shifted significand with sticky folded into bit 0
// ---------------------------------------------------------------------------
module fp32_sticky_shifter
    import fp32_pkg::*;
(
    input  logic [SIG_W-1:0] sig_in,
    input  logic [3:0]       amount,
    output logic [SIG_W-1:0] sig_out
);

    logic [SIG_W-1:0] lost_mask;
    logic             lost;

    // The mask covers exactly the bits that fall off; for amount = 0 it is
    // empty and the value passes through untouched.
    always_comb begin
        lost_mask = (SIG_W'(1) << amount) - SIG_W'(1);
        lost      = |(sig_in & lost_mask);
        sig_out   = (sig_in >> amount) | {{(SIG_W-1){1'b0}}, lost};
    end

endmodule

// File: rtl/fp32_align_stage.sv
// ---------------------------------------------------------------------------
// fp32_align_stage
// Operand front end for the FP32 adder. Captures A, B and the add/sub select,
// unpacks both operands, detects NaN/Inf bypass cases, orders the operands
// by magnitude and shifts the smaller significand right, SHIFT_STEP bits per
// cycle, keeping a sticky bit.
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   en                clock enable, freezes everything when low
//   load              start request, honoured only in IDLE or DONE
//   sub, a, b         operation select and IEEE-754 operands
//   big_sign          sign of the larger-magnitude operand (B sign flipped on sub)
//   eff_sub           effective subtraction
//   exp_out           common (larger) effective exponent
//   mant_big          larger significand {hidden, frac, GRS=0}
//   mant_small        aligned smaller significand, bit 0 sticky
//   special           bypass flag; special_result holds the bypass value
//   busy, ready       busy in UNPACK/ALIGN, ready in DONE
// ---------------------------------------------------------------------------
module fp32_align_stage
    import fp32_pkg::*;
#(
    parameter int SHIFT_STEP = 1,
    parameter int MAX_SHIFT  = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             sub,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             big_sign,
    output logic             eff_sub,
    output logic [EXP_W-1:0] exp_out,
    output logic [SIG_W-1:0] mant_big,
    output logic [SIG_W-1:0] mant_small,
    output logic             special,
    output logic [31:0]      special_result,
    output logic             busy,
    output logic             ready
);

    localparam logic [7:0] STEP_8      = 8'(SHIFT_STEP);
    localparam logic [3:0] STEP_4      = 4'(SHIFT_STEP);
    localparam logic [7:0] MAX_SHIFT_8 = 8'(MAX_SHIFT);

    state_e           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             sub_q, sub_d;
    logic             big_sign_q, big_sign_d;
    logic             eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [SIG_W-1:0] mant_big_q, mant_big_d;
    logic [SIG_W-1:0] mant_small_q, mant_small_d;
    logic             special_q, special_d;
    logic [31:0]      special_result_q, special_result_d;
    logic [7:0]       dist_q, dist_d;

    operand_t         op_a, op_b, op_big, op_small;
    logic             swap;
    logic [7:0]       diff;
    logic             nan_a, nan_b, inf_a, inf_b;
    logic             eff_sub_now;
    logic [3:0]       step_amt;
    logic [7:0]       dist_next;
    logic [SIG_W-1:0] shifted;

    fp32_sticky_shifter u_shifter (
        .sig_in  (mant_small_q),
        .amount  (step_amt),
        .sig_out (shifted)
    );

    // Unpack and classification of the captured operands. Comparing the
    // 31-bit {exp, frac} field is a pure magnitude compare; ties keep A big,
    // which also guarantees exp_big >= exp_small so diff never wraps.
    always_comb begin
        op_a        = unpack_op(a_q, 1'b0);
        op_b        = unpack_op(b_q, sub_q);
        swap        = (b_q[30:0] > a_q[30:0]);
        op_big      = swap ? op_b : op_a;
        op_small    = swap ? op_a : op_b;
        diff        = op_big.exp - op_small.exp;
        nan_a       = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
        nan_b       = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);
        inf_a       = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
        inf_b       = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
        eff_sub_now = op_a.sign ^ op_b.sign;
        step_amt    = (dist_q > STEP_8) ? STEP_4 : dist_q[3:0];
        dist_next   = dist_q - {4'b0000, step_amt};
    end

    // Next-state and datapath update. Everything defaults to hold, so a low
    // enable simply leaves the whole block as it is.
    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        b_d              = b_q;
        sub_d            = sub_q;
        big_sign_d       = big_sign_q;
        eff_sub_d        = eff_sub_q;
        exp_d            = exp_q;
        mant_big_d       = mant_big_q;
        mant_small_d     = mant_small_q;
        special_d        = special_q;
        special_result_d = special_result_q;
        dist_d           = dist_q;

        if (en) begin
            case (state_q)
                IDLE, DONE: begin
                    if (load) begin
                        a_d     = a;
                        b_d     = b;
                        sub_d   = sub;
                        state_d = UNPACK;
                    end
                end

                UNPACK: begin
                    big_sign_d   = op_big.sign;
                    eff_sub_d    = eff_sub_now;
                    exp_d        = op_big.exp;
                    mant_big_d   = op_big.sig;
                    mant_small_d = op_small.sig;
                    dist_d       = '0;
                    special_d    = 1'b1;
                    if (nan_a || nan_b || (inf_a && inf_b && eff_sub_now)) begin
                        special_result_d = QNAN;
                        state_d          = DONE;
                    end else if (inf_a || inf_b) begin
                        special_result_d = {(inf_a ? op_a.sign : op_b.sign), PINF[30:0]};
                        state_d          = DONE;
                    end else begin
                        special_d        = 1'b0;
                        special_result_d = '0;
                        if (diff > MAX_SHIFT_8) begin
                            // Too far apart to matter except as a sticky bit.
                            mant_small_d = {{(SIG_W-1){1'b0}}, |op_small.sig};
                            state_d      = DONE;
                        end else begin
                            dist_d  = diff;
                            state_d = (diff != '0) ? ALIGN : DONE;
                        end
                    end
                end

                ALIGN: begin
                    mant_small_d = shifted;
                    dist_d       = dist_next;
                    if (dist_next == '0) begin
                        state_d = DONE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // State register; reset aborts any alignment in flight and clears every
    // output so no partial result can appear as ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            a_q              <= '0;
            b_q              <= '0;
            sub_q            <= 1'b0;
            big_sign_q       <= 1'b0;
            eff_sub_q        <= 1'b0;
            exp_q            <= '0;
            mant_big_q       <= '0;
            mant_small_q     <= '0;
            special_q        <= 1'b0;
            special_result_q <= '0;
            dist_q           <= '0;
        end else begin
            state_q          <= state_d;
            a_q              <= a_d;
            b_q              <= b_d;
            sub_q            <= sub_d;
            big_sign_q       <= big_sign_d;
            eff_sub_q        <= eff_sub_d;
            exp_q            <= exp_d;
            mant_big_q       <= mant_big_d;
            mant_small_q     <= mant_small_d;
            special_q        <= special_d;
            special_result_q <= special_result_d;
            dist_q           <= dist_d;
        end
    end

    assign big_sign       = big_sign_q;
    assign eff_sub        = eff_sub_q;
    assign exp_out        = exp_q;
    assign mant_big       = mant_big_q;
    assign mant_small     = mant_small_q;
    assign special        = special_q;
    assign special_result = special_result_q;
    assign busy           = (state_q == UNPACK) || (state_q == ALIGN);
    assign ready          = (state_q == DONE);

endmodule

// File: tb/tb_fp32_align_stage.sv
// ---------------------------------------------------------------------------
// tb_fp32_align_stage
// Self-checking bench for fp32_align_stage: a table of hand-computed
// vectors, control-path sequences (load while busy, enable drop, reset
// mid-alignment, load with enable low) and randomized operands checked
// against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp32_align_stage;

    localparam int STEP    = 1;
    localparam int MAXSH   = 26;
    localparam int TIMEOUT = 300;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        special;
        logic [31:0] result;
        logic        sign;
        logic        eff;
        logic [7:0]  expo;
        logic [26:0] mb;
        logic [26:0] ms;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        big_sign;
    logic        eff_sub;
    logic [7:0]  exp_out;
    logic [26:0] mant_big;
    logic [26:0] mant_small;
    logic        special;
    logic [31:0] special_result;
    logic        busy;
    logic        ready;

    int checks = 0;
    int fails  = 0;

    fp32_align_stage #(
        .SHIFT_STEP (STEP),
        .MAX_SHIFT  (MAXSH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .load           (load),
        .sub            (sub),
        .a              (a),
        .b              (b),
        .big_sign       (big_sign),
        .eff_sub        (eff_sub),
        .exp_out        (exp_out),
        .mant_big       (mant_big),
        .mant_small     (mant_small),
        .special        (special),
        .special_result (special_result),
        .busy           (busy),
        .ready          (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: plain arithmetic on exponents and significands.
    // The aligned value is one wide shift with everything below the cut
    // collapsed into a sticky bit, rather than a cycle-by-cycle shift.
    function automatic vec_t refModel(input logic [31:0] ai, input logic [31:0] bi,
                                      input logic si);
        vec_t   r;
        logic   sa, sb, swp, nan_x, nan_y, inf_x, inf_y;
        int     ea, eb, ebig, esmall, d;
        longint sig_a, sig_b, full_big, full_small, rem;
        r       = '{default: '0};
        r.a     = ai;
        r.b     = bi;
        r.sub   = si;
        sa      = ai[31];
        sb      = bi[31] ^ si;
        r.eff   = sa ^ sb;
        ea      = int'(ai[30:23]);
        eb      = int'(bi[30:23]);
        nan_x   = (ea == 255) && (ai[22:0] != 0);
        nan_y   = (eb == 255) && (bi[22:0] != 0);
        inf_x   = (ea == 255) && (ai[22:0] == 0);
        inf_y   = (eb == 255) && (bi[22:0] == 0);
        sig_a   = longint'(ai[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
        sig_b   = longint'(bi[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        swp          = bi[30:0] > ai[30:0];
        r.sign       = swp ? sb : sa;
        ebig         = swp ? eb : ea;
        esmall       = swp ? ea : eb;
        full_big     = (swp ? sig_b : sig_a) * 8;
        full_small   = (swp ? sig_a : sig_b) * 8;
        d            = ebig - esmall;
        r.expo       = 8'(ebig);
        r.mb         = 27'(full_big);
        if (nan_x || nan_y || (inf_x && inf_y && r.eff)) begin
            r.special = 1'b1;
            r.result  = 32'h7FC0_0000;
            r.lat     = 2;
        end else if (inf_x || inf_y) begin
            r.special = 1'b1;
            r.result  = {(inf_x ? sa : sb), 31'h7F80_0000};
            r.lat     = 2;
        end else if (d > MAXSH) begin
            r.ms  = (full_small != 0) ? 27'd1 : 27'd0;
            r.lat = 2;
        end else begin
            rem   = full_small % (64'd1 << d);
            r.ms  = 27'((full_small >> d) | ((rem != 0) ? 64'd1 : 64'd0));
            r.lat = 2 + (d + STEP - 1) / STEP;
        end
        return r;
    endfunction

    // Present operands with load for one rising edge; ready must be low
    // right after that edge.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv);
        @(negedge clk);
        a    = av;
        b    = bv;
        sub  = sv;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        checkOutput("ready_drop", {31'b0, ready}, 32'd0);
    endtask

    // Count edges (load edge = 1) until ready. mode 1 drops en for five
    // edges mid-alignment, mode 2 pulses load with other operands while busy.
    task automatic waitReady(input int mode, output int cycles);
        cycles = 1;
        while (!ready && cycles < TIMEOUT) begin
            @(negedge clk);
            en   = !(mode == 1 && cycles >= 5 && cycles < 10);
            load = (mode == 2 && cycles == 5);
            if (load) begin
                a   = 32'h40D8_0000;
                b   = 32'h4040_0000;
                sub = 1'b1;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        load = 1'b0;
        en   = 1'b1;
        if (!ready) checkOutput("ready_timeout", {31'b0, ready}, 32'd1);
    endtask

    task automatic checkVec(input vec_t e, input int lat, input string tag);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(e.lat));
        checkOutput({tag, ".special"}, {31'b0, special}, {31'b0, e.special});
        if (e.special) begin
            checkOutput({tag, ".special_result"}, special_result, e.result);
        end else begin
            checkOutput({tag, ".big_sign"}, {31'b0, big_sign}, {31'b0, e.sign});
            checkOutput({tag, ".eff_sub"}, {31'b0, eff_sub}, {31'b0, e.eff});
            checkOutput({tag, ".exp_out"}, {24'b0, exp_out}, {24'b0, e.expo});
            checkOutput({tag, ".mant_big"}, {5'b0, mant_big}, {5'b0, e.mb});
            checkOutput({tag, ".mant_small"}, {5'b0, mant_small}, {5'b0, e.ms});
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ready"}, {31'b0, ready}, 32'd0);
        checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, ".special"}, {31'b0, special}, 32'd0);
        checkOutput({tag, ".special_result"}, special_result, 32'd0);
        checkOutput({tag, ".signs"}, {30'b0, big_sign, eff_sub}, 32'd0);
        checkOutput({tag, ".exp_out"}, {24'b0, exp_out}, 32'd0);
        checkOutput({tag, ".mant_big"}, {5'b0, mant_big}, 32'd0);
        checkOutput({tag, ".mant_small"}, {5'b0, mant_small}, 32'd0);
    endtask

    initial begin
        vec_t        vecs[12];
        vec_t        e;
        int          cyc;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0]  = '{a:32'h40D80000, b:32'h40400000, sub:0, special:0, result:0, sign:0, eff:0,
                     expo:8'h81, mb:27'h6C00000, ms:27'h3000000, lat:3};
        vecs[1]  = '{a:32'h4B000000, b:32'h3F800000, sub:0, special:0, result:0, sign:0, eff:0,
                     expo:8'h96, mb:27'h4000000, ms:27'h0000008, lat:25};
        vecs[2]  = '{a:32'h7F000000, b:32'h40000000, sub:0, special:0, result:0, sign:0, eff:0,
                     expo:8'hFE, mb:27'h4000000, ms:27'h0000001, lat:2};
        vecs[3]  = '{a:32'h7F800000, b:32'hFF800000, sub:0, special:1, result:32'h7FC00000,
                     sign:0, eff:0, expo:0, mb:0, ms:0, lat:2};
        vecs[4]  = '{a:32'h3A03126F, b:32'hFF800000, sub:0, special:1, result:32'hFF800000,
                     sign:0, eff:0, expo:0, mb:0, ms:0, lat:2};
        vecs[5]  = '{a:32'h40000000, b:32'h40000000, sub:1, special:0, result:0, sign:0, eff:1,
                     expo:8'h80, mb:27'h4000000, ms:27'h4000000, lat:2};
        vecs[6]  = '{a:32'h7FC00001, b:32'h3F800000, sub:0, special:1, result:32'h7FC00000,
                     sign:0, eff:0, expo:0, mb:0, ms:0, lat:2};
        vecs[7]  = '{a:32'h3F800000, b:32'hC0000000, sub:0, special:0, result:0, sign:1, eff:1,
                     expo:8'h80, mb:27'h4000000, ms:27'h2000000, lat:3};
        vecs[8]  = '{a:32'h00000000, b:32'h00000000, sub:0, special:0, result:0, sign:0, eff:0,
                     expo:8'h01, mb:27'h0, ms:27'h0, lat:2};
        vecs[9]  = '{a:32'h7F800000, b:32'h7F800000, sub:1, special:1, result:32'h7FC00000,
                     sign:0, eff:0, expo:0, mb:0, ms:0, lat:2};
        vecs[10] = '{a:32'h00000003, b:32'h00000001, sub:0, special:0, result:0, sign:0, eff:0,
                     expo:8'h01, mb:27'h18, ms:27'h8, lat:2};
        vecs[11] = '{a:32'h41800000, b:32'h3F800001, sub:0, special:0, result:0, sign:0, eff:0,
                     expo:8'h83, mb:27'h4000000, ms:27'h0400001, lat:6};

        rst  = 1'b0;
        en   = 1'b1;
        load = 1'b0;
        sub  = 1'b0;
        a    = '0;
        b    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub);
            waitReady(0, cyc);
            checkVec(vecs[i], cyc, $sformatf("vec%0d", i));
        end

        // Load with en low must be ignored; DONE outputs stay put.
        @(negedge clk);
        en   = 1'b0;
        load = 1'b1;
        a    = 32'h4B000000;
        b    = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("en_low.ready", {31'b0, ready}, 32'd1);
        checkOutput("en_low.exp_out", {24'b0, exp_out}, {24'b0, vecs[11].expo});
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("en_low.after", {31'b0, ready}, 32'd1);

        // Load pulse while busy: result belongs to the first operands.
        applyStimulus(vecs[1].a, vecs[1].b, vecs[1].sub);
        waitReady(2, cyc);
        checkVec(vecs[1], cyc, "load_busy");

        // Enable dropped for five edges mid-alignment stretches latency by five.
        e = vecs[1];
        e.lat = e.lat + 5;
        applyStimulus(vecs[1].a, vecs[1].b, vecs[1].sub);
        waitReady(1, cyc);
        checkVec(e, cyc, "en_drop");

        // Reset in the middle of alignment clears outputs immediately.
        applyStimulus(vecs[1].a, vecs[1].b, vecs[1].sub);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAllZero("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("post_reset.ready", {31'b0, ready}, 32'd0);
        checkOutput("post_reset.busy", {31'b0, busy}, 32'd0);

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) rb[30:23] = 8'(ra[30:23] - 8'($urandom_range(0, 30)));
            if ($urandom_range(0, 15) == 0) ra[30:23] = 8'hFF;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'hFF;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'h00;
            if ($urandom_range(0, 31) == 0) rb = ra;
            e = refModel(ra, rb, rs);
            applyStimulus(ra, rb, rs);
            waitReady(0, cyc);
            checkVec(e, cyc, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fp32_align_stage.md
Name: fp32_align_stage

Overview:
- Front-end operand stage feeding the FP32 addition stage.
- Accepts two IEEE-754 single-precision operands and an add/subtract select, then unpacks both and detects specials (NaN/Inf).
- Orders operands by magnitude and right-shifts the smaller significand over several cycles with guard/round/sticky retention.
- Presents an aligned significand pair, common exponent and effective operation, ready for the downstream adder to consume.

Parameters:
- SHIFT_STEP, 1: max bits the small significand shifts per ALIGN cycle. Legal values: 1, 2, 4, 8.
- MAX_SHIFT, 26: difference above which the small significand collapses directly to sticky-only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when low, all state and outputs hold.
- load  input  1  start request; sampled in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A-B (flips B sign).
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- big_sign  output  1  sign of the larger-magnitude operand (post sub-flip).
- eff_sub  output  1  effective subtraction, i.e. sign(A) XOR sign(B) post-flip.
- exp_out  output  8  common (larger) exponent; denormals are reported as 1.
- mant_big  output  27  {hidden, frac[22:0], G, R, S} of the larger operand; GRS = 0.
- mant_small  output  27  aligned smaller significand; bit0 is sticky.
- special  output  1  result is fully determined; downstream bypasses.
- special_result  output  32  bypass value, valid when special = 1.
- busy  output  1  high in UNPACK and ALIGN.
- ready  output  1  high in DONE; outputs are valid.

Behaviour:
- Reset (rst = 0, async):
  - State goes to IDLE.
  - All outputs go to 0, including ready, busy and special.
- Sub-flip: B sign is inverted when sub = 1, captured at load.
- IDLE:
  - load = 1 and en = 1 registers a, b and sub, then moves to UNPACK.
- UNPACK (1 cycle):
  - Hidden bit = (exp != 0). Effective exponent = (exp == 0) ? 1 : exp.
  - Compare {exp, frac} magnitude. If B > A, swap; ties keep A as big.
  - Load mant_big/mant_small as {hidden, frac, 3'b000}. Compute d = exp_big - exp_small.
  - Special detection, first match wins:
    - Any NaN gives 0x7FC00000.
    - Inf with Inf and eff_sub = 1 gives 0x7FC00000.
    - Otherwise, any Inf gives {sign_of_inf, 0x7F800000[30:0]}.
  - Specials set special = 1 and go directly to DONE. mant/exp outputs are don't-care but held at their UNPACK values.
  - If d > MAX_SHIFT: mant_small becomes 27'h1 if the small significand is nonzero, else 0. d is set to 0.
  - Next state is ALIGN if d > 0, else DONE.
- ALIGN:
  - Each enabled cycle shifts by s = min(d, SHIFT_STEP) and decrements d by s.
  - mant_small[0] = OR of all bits shifted out OR old bit0 (sticky never clears).
  - Go to DONE when d reaches 0.
  - Latency from the load cycle to ready: 2 + ceil(d/SHIFT_STEP) cycles.
- DONE:
  - ready = 1 and outputs are held stable until the next load.
  - load = 1 drops ready the next cycle and re-enters UNPACK with new operands.
- Load ignored while busy: no restart, no operand capture.
- en = 0 in any state freezes the FSM, counters and outputs. load is ignored while en = 0.
- Zero operands are not special; they flow through the normal path with mant = 0.
- Reset asserted mid-ALIGN aborts immediately. No partial result is ever flagged ready.

Decomposition:
- Shared package fp32_pkg holds:
  - Field widths: EXP_W = 8, FRAC_W = 23, SIG_W = 27.
  - Constants: QNAN = 32'h7FC00000, PINF = 32'h7F800000.
  - State enum: IDLE, UNPACK, ALIGN, DONE.
  - Unpacked-operand struct: sign, exp, sig.
- One natural sub-module, fp32_sticky_shifter: combinational right shift by 0..SHIFT_STEP with sticky OR-reduction. Instantiated once inside the ALIGN datapath.

Test Plan:
- Normal align, d = 1: a = 0x40D80000 (6.75), b = 0x40400000 (3.0), sub = 0, SHIFT_STEP = 1. Expect ready 3 cycles after load; exp_out = 0x81; mant_big = 0x6C00000; mant_small = 0x3000000; eff_sub = 0; special = 0.
- Long align, d = 23: a = 0x4B000000, b = 0x3F800000. Expect 25 cycles to ready; exp_out = 0x96; mant_big = 0x4000000; mant_small = 0x0000008.
- Sticky collapse, d = 126: a = 0x7F000000, b = 0x40000000. Expect exp_out = 0xFE; mant_small = 0x0000001; ready in 2 cycles.
- Specials:
  - a = 0x7F800000, b = 0xFF800000, sub = 0: special = 1, special_result = 0x7FC00000.
  - a = 0x3A03126F, b = 0xFF800000: special_result = 0xFF800000.
- Equal magnitude with sub: a = b = 0x40000000, sub = 1. Expect eff_sub = 1; big_sign = 0; mant_big = mant_small = 0x4000000; exp_out = 0x80; no swap.
- Control:
  - Pulse load during ALIGN with different operands: result matches the first operands.
  - Drop en for 5 cycles mid-ALIGN: latency grows by exactly 5.
  - Assert rst mid-ALIGN: all outputs are 0 on the same edge; ready stays 0.
